// File: rtl/vsim_send_framer_if.sv
// Sender-to-framer beat strobe plus framer-to-host show-ahead handshake.
// The framer itself connects through the slave modport.
interface vsim_send_framer_if #(
    parameter int width = 32
);
    logic             enq__ENA;
    logic [width-1:0] enq_v;
    logic             enq_last;
    logic             enq__RDY;
    logic             host_valid;
    logic [width-1:0] host_data;
    logic             host_last;
    logic             host_ready;

    modport master (
        output enq__ENA, enq_v, enq_last, host_ready,
        input  enq__RDY, host_valid, host_data, host_last
    );

    modport slave (
        input  enq__ENA, enq_v, enq_last, host_ready,
        output enq__RDY, host_valid, host_data, host_last
    );
endinterface

// File: rtl/vsim_send_framer.sv
// Transmit framer: buffers PipeInLast beats in a show-ahead FIFO, caps frame length,
// and optionally releases beats to the host only once a whole frame is stored.
module vsim_send_framer #(
    parameter int width     = 32,
    parameter int depth     = 16,
    parameter int max_beats = 8,
    parameter int store_fwd = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    vsim_send_framer_if.slave bus,
    output logic [31:0]       frame_count,
    output logic              err_long,
    output logic              err_proto
);
    localparam int AW = $clog2(depth);
    localparam int BW = (max_beats > 1) ? $clog2(max_beats) : 1;
    localparam logic [AW:0]   DEPTH_V  = (AW+1)'(depth);
    localparam logic [BW-1:0] LAST_IDX = BW'(max_beats - 1);

    // A frame longer than the FIFO can never complete under store-and-forward.
    if (store_fwd != 0 && max_beats > depth) begin : g_cfg_check
        $error("vsim_send_framer: store_fwd requires max_beats <= depth");
    end

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   beat_cnt, beat_cnt_nxt;
    logic            at_limit, last_eff, forced;

    logic [width:0]  mem [depth];
    logic [width:0]  head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     occ, pend;
    logic            vld, push, pop, push_last, pop_last;

    assign bus.enq__RDY = nRST & (occ < DEPTH_V);

    assign vld  = (store_fwd != 0) ? (pend != '0) : (occ != '0);
    assign head = mem[rd_ptr];

    assign bus.host_valid = vld;
    assign bus.host_data  = vld ? head[width-1:0] : '0;
    assign bus.host_last  = vld & head[width];

    assign push      = bus.enq__ENA & bus.enq__RDY;
    assign pop       = vld & bus.host_ready;
    assign push_last = push & last_eff;
    assign pop_last  = pop & head[width];

    // Input framing FSM: tracks the beat index within the current frame.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (push && !last_eff) begin
                    state_nxt    = IN_FRAME;
                    beat_cnt_nxt = BW'(1);
                end
            end
            IN_FRAME: begin
                if (push) begin
                    if (last_eff) begin
                        state_nxt    = IDLE;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt    = IDLE;
                beat_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        at_limit = (beat_cnt == LAST_IDX);
        last_eff = bus.enq_last | at_limit;
        forced   = push & ~bus.enq_last & at_limit;
    end

    // Payload storage carries the effective last flag alongside the data; no reset needed.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {last_eff, bus.enq_v};
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            pend        <= '0;
            frame_count <= '0;
            err_long    <= 1'b0;
            err_proto   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            case ({push_last, pop_last})
                2'b10:   pend <= pend + 1'b1;
                2'b01:   pend <= pend - 1'b1;
                default: pend <= pend;
            endcase
            if (pop_last) begin
                frame_count <= frame_count + 32'd1;
            end
            if (forced) begin
                err_long <= 1'b1;
            end
            if (bus.enq__ENA && !bus.enq__RDY) begin
                err_proto <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vsim_send_framer.sv
// Bench for vsim_send_framer: a store-and-forward and a cut-through instance share stimulus,
// each scored against its own queue-based model of the framing and delivery rules.
module tb_vsim_send_framer;
    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int MAXB  = 8;

    logic         CLK        = 1'b0;
    logic         nRST       = 1'b0;
    logic         enq_ena    = 1'b0;
    logic [W-1:0] enq_v      = '0;
    logic         enq_last   = 1'b0;
    logic         host_ready = 1'b0;

    logic         rdy [2];
    logic         hv  [2];
    logic         hl  [2];
    logic [W-1:0] hd  [2];
    logic [31:0]  fc  [2];
    logic         el  [2];
    logic         ep  [2];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, g, act, exp, $time);
    endtask

    // Instance 0 is store-and-forward, instance 1 is cut-through.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam bit SF = (g == 0);

        vsim_send_framer_if #(.width(W)) bus ();

        assign bus.enq__ENA   = enq_ena;
        assign bus.enq_v      = enq_v;
        assign bus.enq_last   = enq_last;
        assign bus.host_ready = host_ready;
        assign rdy[g] = bus.enq__RDY;
        assign hv[g]  = bus.host_valid;
        assign hd[g]  = bus.host_data;
        assign hl[g]  = bus.host_last;

        vsim_send_framer #(
            .width(W), .depth(DEPTH), .max_beats(MAXB), .store_fwd(SF ? 1 : 0)
        ) u_dut (
            .CLK(CLK),
            .nRST(nRST),
            .bus(bus.slave),
            .frame_count(fc[g]),
            .err_long(el[g]),
            .err_proto(ep[g])
        );

        // Model state: stored beats as {last, data}, beat index in the open frame, counters.
        logic [W:0]  q[$];
        int          bcnt = 0;
        logic [31:0] m_fc = '0;
        logic        m_el = 1'b0;
        logic        m_ep = 1'b0;
        bit          live = 1'b0;

        always @(negedge CLK) begin : mon
            int         npend;
            logic       ev, er, lf;
            logic [W:0] hb;
            npend = 0;
            foreach (q[i]) if (q[i][W]) npend++;
            ev = SF ? (npend > 0) : (q.size() > 0);
            er = nRST && (q.size() < DEPTH);
            if (live) begin
                chk("enq_rdy", g, rdy[g], er);
                chk("host_valid", g, hv[g], ev);
                chk("frame_count", g, fc[g], m_fc);
                chk("err_long", g, el[g], m_el);
                chk("err_proto", g, ep[g], m_ep);
                if (ev) begin
                    chk("host_data", g, hd[g], q[0][W-1:0]);
                    chk("host_last", g, hl[g], q[0][W]);
                end
            end
            if (!nRST) begin
                q.delete();
                bcnt = 0;
                m_fc = '0;
                m_el = 1'b0;
                m_ep = 1'b0;
                live = 1'b1;
            end else begin
                if (enq_ena && !er) m_ep = 1'b1;
                if (ev && host_ready) begin
                    hb = q.pop_front();
                    if (hb[W]) m_fc = m_fc + 32'd1;
                end
                if (enq_ena && er) begin
                    lf = enq_last || (bcnt == MAXB - 1);
                    if (!enq_last && bcnt == MAXB - 1) m_el = 1'b1;
                    q.push_back({lf, enq_v});
                    bcnt = lf ? 0 : bcnt + 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d, input logic l);
        enq_ena  = 1'b1;
        enq_v    = d;
        enq_last = l;
        step();
        enq_ena  = 1'b0;
        enq_last = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        step();
        chk("rdy_in_reset", 0, rdy[0], 0);
        chk("hv_after_reset", 0, hv[0], 0);
        chk("fc_after_reset", 0, fc[0], 0);
        nRST = 1'b1;
        step();
        chk("rdy_after_reset", 0, rdy[0], 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        host_ready = 1'b1;
        while ((hv[0] || hv[1]) && k < 64) begin
            step();
            k++;
        end
        chk("drain_bounded", 0, (k < 64), 1);
    endtask

    initial begin
        repeat (2) step();

        // Three-beat frame: store-and-forward holds it until the last beat lands.
        do_reset();
        host_ready = 1'b1;
        push(32'h11, 1'b0);
        push(32'h22, 1'b0);
        chk("sf_holds_partial", 0, hv[0], 0);
        chk("ct_shows_partial", 1, hv[1], 1);
        push(32'h33, 1'b1);
        chk("sf_valid_after_last", 0, hv[0], 1);
        drain();
        chk("t1_frames", 0, fc[0], 1);
        chk("t1_frames", 1, fc[1], 1);

        // Fill to depth with host stalled, then one overflow attempt.
        do_reset();
        host_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(32'h100 + i, 1'b1);
        chk("full_rdy", 0, rdy[0], 0);
        chk("full_rdy", 1, rdy[1], 0);
        chk("no_proto_yet", 0, ep[0], 0);
        push(32'hDEAD, 1'b1);
        chk("overflow_proto", 0, ep[0], 1);
        chk("overflow_proto", 1, ep[1], 1);
        drain();
        chk("t2_frames", 0, fc[0], 16);
        chk("t2_frames", 1, fc[1], 16);

        // Ten beats without a sender last: beat 8 is cut, beats 9-10 form a second frame.
        do_reset();
        host_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            push(W'(i), (i == 10));
            if (i == 7) chk("no_long_before_limit", 0, el[0], 0);
        end
        chk("long_set", 0, el[0], 1);
        chk("long_set", 1, el[1], 1);
        drain();
        chk("t3_frames", 0, fc[0], 2);
        chk("t3_frames", 1, fc[1], 2);

        // Steady streaming at occupancy 5 through several pointer wraps.
        do_reset();
        host_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h400 + i, 1'b1);
        host_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            enq_ena  = 1'b1;
            enq_v    = $urandom;
            enq_last = 1'b1;
            step();
            chk("stream_rdy", 0, rdy[0], 1);
            chk("stream_valid", 0, hv[0], 1);
        end
        enq_ena  = 1'b0;
        enq_last = 1'b0;
        chk("stream_frames", 0, fc[0], 30);
        drain();
        chk("t4_frames", 0, fc[0], 35);
        chk("t4_frames", 1, fc[1], 35);

        // Reset in the middle of a frame discards it; a fresh frame goes through intact.
        do_reset();
        host_ready = 1'b1;
        push(32'h501, 1'b0);
        push(32'h502, 1'b0);
        nRST = 1'b0;
        step();
        chk("midrst_hv", 0, hv[0], 0);
        chk("midrst_fc", 1, fc[1], 0);
        chk("midrst_rdy", 0, rdy[0], 0);
        nRST = 1'b1;
        step();
        chk("midrst_rdy_back", 0, rdy[0], 1);
        for (int i = 0; i < 4; i++) push(32'h510 + i, (i == 3));
        drain();
        chk("t5_frames", 0, fc[0], 1);
        chk("t5_frames", 1, fc[1], 1);

        // Pop of one complete frame coincides with push of the next one.
        do_reset();
        host_ready = 1'b0;
        push(32'h600, 1'b1);
        host_ready = 1'b1;
        push(32'h601, 1'b1);
        chk("swap_valid", 0, hv[0], 1);
        chk("swap_frames", 0, fc[0], 1);
        drain();
        chk("t6_frames", 0, fc[0], 2);

        // Randomized traffic with occasional resets; the monitors score every cycle.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            enq_ena    = ($urandom_range(3) != 0);
            enq_v      = $urandom;
            enq_last   = ($urandom_range(4) == 0);
            host_ready = ($urandom_range(9) < 7);
            nRST       = ($urandom_range(499) != 0);
            step();
        end
        enq_ena  = 1'b0;
        enq_last = 1'b0;
        nRST     = 1'b1;
        drain();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vsim_send_framer.md
Name: vsim_send_framer

Overview:
- Transmit-side counterpart of the simulation host-message receiver: accepts beats on the PipeInLast protocol from the design under simulation and buffers them in a FIFO.
- Presents beats to a host-side handshake; a separate thin DPI wrapper drains that handshake into the simulator host process.
- Enforces frame-length limits and optionally forwards only complete frames (store-and-forward), so the host never sees a partial message.

Parameters:
- width, 32, payload bits per beat
- depth, 16, FIFO entries (power of 2, ≥2)
- max_beats, 8, maximum beats per frame; the beat at index max_beats-1 is forced to last
- store_fwd, 1, 1 = host_valid only while ≥1 complete frame is buffered; 0 = cut-through

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- enq__ENA  in  1  beat strobe from sender
- enq_v  in  width  beat payload
- enq_last  in  1  final beat of frame
- enq__RDY  out  1  block can accept a beat this cycle
- host_valid  out  1  head beat available to host
- host_data  out  width  head payload
- host_last  out  1  head beat ends frame
- host_ready  in  1  host consumes head beat
- frame_count  out  32  frames fully delivered to host
- err_long  out  1  sticky: a frame was truncated at max_beats
- err_proto  out  1  sticky: enq__ENA asserted while enq__RDY=0

Behaviour:
- Interface:
  - One clock, CLK.
  - Reset nRST is synchronous and active-low: all state updates at posedge CLK when nRST==0.
  - Reset clears FIFO pointers and occupancy, beat counter, frames_pending, frame_count, err_long and err_proto.
  - A partial frame in flight is discarded at reset.
- Reset values of outputs:
  - enq__RDY=0 while nRST==0; otherwise enq__RDY = (occupancy < depth).
  - host_valid=0, host_data=0, host_last=0, frame_count=0, err_long=0, err_proto=0.
- Push:
  - On enq__ENA && enq__RDY, write {last', enq_v} at the write pointer.
  - last' = enq_last OR (beat_cnt == max_beats-1).
  - If the beat is forced (enq_last=0 and beat_cnt==max_beats-1), set err_long.
  - Subsequent beats start a new frame.
- Input state machine:
  - IDLE: beat_cnt=0.
  - IN_FRAME: beat_cnt>0.
  - Accepted beat with last'=0: beat_cnt+1, state IN_FRAME.
  - Accepted beat with last'=1: beat_cnt=0, state IDLE.
- Protocol errors: enq__ENA && !enq__RDY → beat ignored, err_proto set; there is no other effect.
- Pop:
  - FIFO is show-ahead; host_data and host_last reflect the head entry combinationally.
  - host_valid = (occupancy>0) when store_fwd=0.
  - host_valid = (frames_pending>0) when store_fwd=1.
  - On host_valid && host_ready, advance the read pointer.
  - If the popped beat has last=1, frame_count+1; it wraps at 2^32.
- frames_pending:
  - +1 on a push with last'=1; −1 on a pop with last=1.
  - Both in the same cycle → unchanged.
  - Range 0..depth.
- Simultaneous push and pop:
  - Allowed whenever enq__RDY=1; occupancy unchanged.
  - When full, enq__RDY=0 even if a pop occurs that cycle, so there is no full-bypass path.
- Pointers: log2(depth) bits, wrap modulo depth; occupancy is log2(depth)+1 bits.
- Latency: a beat pushed at edge N is visible at host_data after edge N.
  - store_fwd=0: host_valid from cycle N+1.
  - store_fwd=1: host_valid once its frame's last beat is pushed.
- host_data/host_last are don't-care when host_valid=0; the bench checks them only with host_valid=1.
- Elaboration: $error if store_fwd==1 && max_beats>depth, since that configuration would deadlock.
- err_long and err_proto clear only on reset.

Test Plan:
- Reset, then a 3-beat frame (0x11, 0x22, 0x33 with last on 0x33), host_ready=1, store_fwd=1 → host_valid rises only after the 0x33 push; host sees 0x11, 0x22, 0x33 with host_last on the third beat; frame_count=1.
- store_fwd=0, host_ready=0, push 16 single-beat frames → enq__RDY=0 after the 16th push; a 17th enq__ENA sets err_proto and is dropped. Then host_ready=1 → exactly 16 beats out; frame_count=16.
- 10 beats, no enq_last, max_beats=8 → beat 8 delivered with host_last=1 and err_long=1; beats 9–10 form a second frame ending when the sender asserts last.
- Continuous push and pop with occupancy 5, including pointer wrap past entry 15 → occupancy stays 5; data order preserved across wrap; no dropped or duplicated beats.
- nRST=0 asserted after 2 beats of a 4-beat frame are pushed → next cycle host_valid=0, frame_count=0, enq__RDY=0 during reset, 1 after; a new frame afterwards is delivered intact.
- Same-cycle pop of a last beat and push of a last beat (frames_pending=1) → frames_pending stays 1; host_valid stays 1.
